store_addr_gen: RTL and testbench
=================================

Name: store_addr_gen

Overview:
- Producer side of the memory-backed FIFO. Counterpart of the load-side address generator, which drains from tail to head.
- Accepts data elements from the accelerator stream and issues one store per element at base + size*head.
- Advances the head pointer with wrap and stops on full or when the requested count is reached.
- Waits until all stores are acknowledged, then returns the new head pointer to the FIFO config controller.

Parameters:
- ADDR_W, 64, address width
- PTR_W, 16, FIFO pointer/count width
- DATA_W, 64, store data width
- MAX_OUTST, 8, maximum unacknowledged stores

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid_i  in  1  start request from config controller
- cfg_base_i  in  ADDR_W  FIFO base address
- cfg_depth_i  in  PTR_W  last slot index; ring has depth+1 slots
- cfg_size_i  in  4  element size in bytes
- cfg_head_ptr_i  in  PTR_W  current head (write) pointer
- cfg_tail_ptr_i  in  PTR_W  current tail (read) pointer
- cfg_count_i  in  PTR_W  elements to push this request
- cfg_ack_o  out  1  one-cycle completion pulse
- cfg_head_ptr_o  out  PTR_W  updated head pointer
- cfg_pushed_o  out  PTR_W  elements actually pushed
- cfg_err_o  out  1  request rejected (optional feature)
- data_valid_i  in  1  element available
- data_i  in  DATA_W  element data
- data_ready_o  out  1  element consumed
- st_valid_o  out  1  store request valid
- st_ready_i  in  1  memory accepts store
- st_addr_o  out  ADDR_W  store address
- st_size_o  out  4  store size (= latched cfg_size_i)
- st_data_o  out  DATA_W  store data (= data_i)
- st_resp_i  in  1  one pulse per completed store

Behaviour:
- Reset (async, rst_n=0): state S_IDLE. Outputs cfg_ack_o=0, cfg_err_o=0, st_valid_o=0, data_ready_o=0. head, pushed, outstanding, addr, cfg_head_ptr_o and cfg_pushed_o all 0. Reset mid-request abandons it; no ack is issued.
- States: S_IDLE, S_PIPE, S_DRAIN, S_ACK.
- S_IDLE, on cfg_valid_i:
  - latch base, depth, size, tail (tail is a snapshot, conservative for the whole request), count.
  - head_r = cfg_head_ptr_i; addr_r = base + size*head (product truncated to ADDR_W); pushed = 0.
  - go to S_PIPE.
- next_head = (head_r == depth) ? 0 : head_r + 1.
- full = (next_head == tail_snap). The ring is full when the slot after head equals tail.
- stop = full | (pushed == count).
- issue_ok = S_PIPE & !stop & (outstanding < MAX_OUTST).
- st_valid_o = issue_ok & data_valid_i. data_ready_o = st_valid_o & st_ready_i. These are combinational, zero latency.
- st_addr_o = addr_r. Once st_valid_o is asserted, addr/data are held until the handshake (data_i stable per stream rule).
- On handshake:
  - head_r = next_head; pushed + 1; outstanding + 1.
  - addr_r = (head_r == depth) ? base : addr_r + size.
- Outstanding counter: +1 on handshake, -1 on st_resp_i, unchanged when both occur in the same cycle. st_resp_i with outstanding == 0 is a protocol violation; the counter holds at 0 and an assertion fires.
- S_PIPE -> S_DRAIN when stop is true (evaluated every cycle, including count == 0).
- S_DRAIN -> S_ACK when outstanding == 0, or when outstanding == 1 and st_resp_i is asserted that cycle. No new stores are issued.
- S_ACK: cfg_ack_o = 1 for exactly one cycle, then S_IDLE. cfg_head_ptr_o and cfg_pushed_o update entering S_ACK and hold until the next request's ack.
- cfg_valid_i outside S_IDLE is ignored.

Optional Feature:
- STORE_ADDR_GEN_SIZE_CHECK_EN defined:
  - in S_IDLE, cfg_size_i not in {1,2,4,8} goes directly to S_ACK.
  - cfg_err_o = 1 with the ack; no stores; cfg_head_ptr_o = cfg_head_ptr_i; cfg_pushed_o = 0.
  - cfg_err_o clears on the next accepted request.
- Undefined: the size is used unchecked and cfg_err_o is tied 0.

Test Plan:
- Basic: base=0x1000, depth=7, size=8, head=2, tail=0, count=3, immediate resps -> stores to 0x1010, 0x1018, 0x1020; ack with head=5, pushed=3.
- Wrap: base=0x2000, depth=3, size=8, head=3, tail=2, count=2 -> stores to 0x2018 then 0x2000; head=1, pushed=2.
- Full: depth=3, head=0, tail=0, count=5 -> exactly 3 stores (slots 0, 1, 2); head=3, pushed=3; ack despite data_valid_i still high.
- Backpressure/outstanding: MAX_OUTST=2, st_resp_i withheld -> third store blocked until a resp arrives. Ack comes only in the cycle after the last resp. Simultaneous handshake+resp keeps the count unchanged.
- count=0 -> no stores; ack 2 cycles after cfg_valid_i with head unchanged, pushed=0. Second sub-case: assert rst_n=0 mid-S_PIPE -> all outputs 0 immediately, no ack.
- With STORE_ADDR_GEN_SIZE_CHECK_EN defined: size=3 -> cfg_err_o=1 with ack, zero stores. Without the macro, the same stimulus issues stores at stride 3.

Source files
------------

// File: rtl/store_addr_gen.sv
// store_addr_gen: producer side of the memory-backed FIFO.
// Writes one stream element per store at base + size*head. It advances the
// head with wrap-around and stops when the ring is full or the requested
// count has been pushed. Once every store has been acknowledged, it returns
// the new head pointer to the FIFO config controller.
// Optional build macro STORE_ADDR_GEN_SIZE_CHECK_EN rejects element sizes
// outside {1,2,4,8} and reports the rejection on cfg_err_o.
module store_addr_gen #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned PTR_W     = 16,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [PTR_W-1:0]  cfg_depth_i,
  input  logic [3:0]        cfg_size_i,
  input  logic [PTR_W-1:0]  cfg_head_ptr_i,
  input  logic [PTR_W-1:0]  cfg_tail_ptr_i,
  input  logic [PTR_W-1:0]  cfg_count_i,
  output logic              cfg_ack_o,
  output logic [PTR_W-1:0]  cfg_head_ptr_o,
  output logic [PTR_W-1:0]  cfg_pushed_o,
  output logic              cfg_err_o,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              data_ready_o,
  output logic              st_valid_o,
  input  logic              st_ready_i,
  output logic [ADDR_W-1:0] st_addr_o,
  output logic [3:0]        st_size_o,
  output logic [DATA_W-1:0] st_data_o,
  input  logic              st_resp_i
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {S_IDLE, S_PIPE, S_DRAIN, S_ACK} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [PTR_W-1:0]  depth_r;
  logic [3:0]        size_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W-1:0]  count_r;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  pushed_r;
  logic [ADDR_W-1:0] addr_r;
  logic [OUT_W-1:0]  outst_r;

  logic [PTR_W-1:0]  next_head;
  logic              full;
  logic              stop;
  logic              issue_ok;
  logic              hs;
  logic              drain_done;

  // Ring bookkeeping; the tail snapshot is conservative for the whole request
  assign next_head  = (head_r == depth_r) ? '0 : head_r + PTR_W'(1);
  assign full       = (next_head == tail_r);
  assign stop       = full | (pushed_r == count_r);
  assign issue_ok   = (state == S_PIPE) & ~stop & (outst_r < OUT_W'(MAX_OUTST));
  assign drain_done = (outst_r == '0) | ((outst_r == OUT_W'(1)) & st_resp_i);

  // Zero-latency stream-to-store handshake
  assign st_valid_o   = issue_ok & data_valid_i;
  assign data_ready_o = st_valid_o & st_ready_i;
  assign hs           = data_ready_o;
  assign st_addr_o    = addr_r;
  assign st_size_o    = size_r;
  assign st_data_o    = data_i;

`ifdef STORE_ADDR_GEN_SIZE_CHECK_EN
  logic size_bad_c;
  assign size_bad_c = ~((cfg_size_i == 4'd1) | (cfg_size_i == 4'd2) |
                        (cfg_size_i == 4'd4) | (cfg_size_i == 4'd8));
`else
  assign cfg_err_o = 1'b0;
`endif

  // Request sequencing, pointer/address advance and registered completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      base_r         <= '0;
      depth_r        <= '0;
      size_r         <= '0;
      tail_r         <= '0;
      count_r        <= '0;
      head_r         <= '0;
      pushed_r       <= '0;
      addr_r         <= '0;
      cfg_ack_o      <= 1'b0;
      cfg_head_ptr_o <= '0;
      cfg_pushed_o   <= '0;
`ifdef STORE_ADDR_GEN_SIZE_CHECK_EN
      cfg_err_o      <= 1'b0;
`endif
    end else begin
      cfg_ack_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_valid_i) begin
            base_r   <= cfg_base_i;
            depth_r  <= cfg_depth_i;
            size_r   <= cfg_size_i;
            tail_r   <= cfg_tail_ptr_i;
            count_r  <= cfg_count_i;
            head_r   <= cfg_head_ptr_i;
            pushed_r <= '0;
            addr_r   <= cfg_base_i + ADDR_W'(cfg_size_i) * ADDR_W'(cfg_head_ptr_i);
            state    <= S_PIPE;
`ifdef STORE_ADDR_GEN_SIZE_CHECK_EN
            cfg_err_o <= size_bad_c;
            if (size_bad_c) begin
              state          <= S_ACK;
              cfg_ack_o      <= 1'b1;
              cfg_head_ptr_o <= cfg_head_ptr_i;
              cfg_pushed_o   <= '0;
            end
`endif
          end
        end
        S_PIPE: begin
          if (hs) begin
            head_r   <= next_head;
            pushed_r <= pushed_r + PTR_W'(1);
            addr_r   <= (head_r == depth_r) ? base_r : addr_r + ADDR_W'(size_r);
          end
          if (stop) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state          <= S_ACK;
            cfg_ack_o      <= 1'b1;
            cfg_head_ptr_o <= head_r;
            cfg_pushed_o   <= pushed_r;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Unacknowledged store counter; a stray response at zero leaves it at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r <= '0;
    end else begin
      unique case ({hs, st_resp_i})
        2'b10:   outst_r <= outst_r + OUT_W'(1);
        2'b01:   if (outst_r != '0) outst_r <= outst_r - OUT_W'(1);
        default: outst_r <= outst_r;
      endcase
    end
  end

  // A response with nothing outstanding is a memory-side protocol violation
  a_no_stray_resp: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(st_resp_i && (outst_r == '0)));

endmodule

// File: tb/tb_store_addr_gen.sv
// Self-checking bench for store_addr_gen: scoreboard of expected store
// addresses, auto-responding memory model plus manual response control.
module tb_store_addr_gen;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned PTR_W  = 16;
  localparam int unsigned DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid_i;
  logic [ADDR_W-1:0] cfg_base_i;
  logic [PTR_W-1:0]  cfg_depth_i;
  logic [3:0]        cfg_size_i;
  logic [PTR_W-1:0]  cfg_head_ptr_i;
  logic [PTR_W-1:0]  cfg_tail_ptr_i;
  logic [PTR_W-1:0]  cfg_count_i;
  logic              cfg_ack_o;
  logic [PTR_W-1:0]  cfg_head_ptr_o;
  logic [PTR_W-1:0]  cfg_pushed_o;
  logic              cfg_err_o;
  logic              data_valid_i;
  logic [DATA_W-1:0] data_i;
  logic              data_ready_o;
  logic              st_valid_o;
  logic              st_ready_i;
  logic [ADDR_W-1:0] st_addr_o;
  logic [3:0]        st_size_o;
  logic [DATA_W-1:0] st_data_o;
  logic              st_resp_i;

  logic              resp_auto;
  logic              resp_man;
  logic              auto_en;
  logic [3:0]        cur_size;
  int                n_tests;
  int                n_fail;
  int                hs_cnt;
  int                hs_auto_cnt;
  int                resp_cnt;
  int                last_lat;
  logic [63:0]       exp_q[$];

  assign st_resp_i = resp_auto | resp_man;

  store_addr_gen #(
    .ADDR_W(ADDR_W), .PTR_W(PTR_W), .DATA_W(DATA_W), .MAX_OUTST(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid_i), .cfg_base_i(cfg_base_i), .cfg_depth_i(cfg_depth_i),
    .cfg_size_i(cfg_size_i), .cfg_head_ptr_i(cfg_head_ptr_i),
    .cfg_tail_ptr_i(cfg_tail_ptr_i), .cfg_count_i(cfg_count_i),
    .cfg_ack_o(cfg_ack_o), .cfg_head_ptr_o(cfg_head_ptr_o),
    .cfg_pushed_o(cfg_pushed_o), .cfg_err_o(cfg_err_o),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .st_valid_o(st_valid_o), .st_ready_i(st_ready_i), .st_addr_o(st_addr_o),
    .st_size_o(st_size_o), .st_data_o(st_data_o), .st_resp_i(st_resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Store monitor: pops the scoreboard on every accepted store
  always @(negedge clk) begin
    if (rst_n && st_valid_o) begin
      chk("data_ready", 64'(data_ready_o), 64'(st_ready_i));
      if (st_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_store", 64'(st_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          chk("st_addr", st_addr_o, exp_q.pop_front());
        end
        chk("st_data", st_data_o, data_i);
        chk("st_size", 64'(st_size_o), 64'(cur_size));
        hs_cnt++;
        if (auto_en) hs_auto_cnt++;
      end
    end
  end

  // Memory model: one response per accepted store, the cycle after
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      resp_cnt  = hs_auto_cnt;
      resp_auto = 1'b0;
    end else if (hs_auto_cnt > resp_cnt) begin
      resp_auto = 1'b1;
      resp_cnt++;
    end else begin
      resp_auto = 1'b0;
    end
  end

  task automatic start_req(input logic [63:0] base, input logic [15:0] depth,
                           input logic [3:0] size, input logic [15:0] head,
                           input logic [15:0] tail, input logic [15:0] count);
    @(posedge clk); #1;
    cfg_base_i     = base;
    cfg_depth_i    = depth;
    cfg_size_i     = size;
    cfg_head_ptr_i = head;
    cfg_tail_ptr_i = tail;
    cfg_count_i    = count;
    cur_size       = size;
    cfg_valid_i    = 1'b1;
    @(posedge clk); #1;
    cfg_valid_i    = 1'b0;
  endtask

  task automatic wait_ack(input logic [15:0] exp_head, input logic [15:0] exp_pushed,
                          input logic exp_err, input int max_cyc);
    int got;
    got = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (cfg_ack_o) begin
        got = i;
        break;
      end
    end
    last_lat = got;
    chk("ack_seen", 64'(got != 0), 64'd1);
    if (got != 0) begin
      chk("ack_head", 64'(cfg_head_ptr_o), 64'(exp_head));
      chk("ack_pushed", 64'(cfg_pushed_o), 64'(exp_pushed));
      chk("ack_err", 64'(cfg_err_o), 64'(exp_err));
      chk("stores_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      chk("ack_pulse", 64'(cfg_ack_o), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int hs_before;
    n_tests = 0; n_fail = 0; hs_cnt = 0; hs_auto_cnt = 0; resp_cnt = 0; last_lat = 0;
    rst_n = 1'b0; cfg_valid_i = 1'b0; cfg_base_i = '0; cfg_depth_i = '0;
    cfg_size_i = '0; cfg_head_ptr_i = '0; cfg_tail_ptr_i = '0; cfg_count_i = '0;
    data_valid_i = 1'b0; data_i = '0; st_ready_i = 1'b1;
    resp_auto = 1'b0; resp_man = 1'b0; auto_en = 1'b1; cur_size = '0;

    // Reset values
    @(negedge clk);
    chk("rst_ack", 64'(cfg_ack_o), 64'd0);
    chk("rst_err", 64'(cfg_err_o), 64'd0);
    chk("rst_st_valid", 64'(st_valid_o), 64'd0);
    chk("rst_data_ready", 64'(data_ready_o), 64'd0);
    chk("rst_head", 64'(cfg_head_ptr_o), 64'd0);
    chk("rst_pushed", 64'(cfg_pushed_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic run
    data_valid_i = 1'b1;
    data_i = 64'hA5A5_0000_0000_0001;
    exp_q.push_back(64'h1010); exp_q.push_back(64'h1018); exp_q.push_back(64'h1020);
    start_req(64'h1000, 16'd7, 4'd8, 16'd2, 16'd0, 16'd3);
    wait_ack(16'd5, 16'd3, 1'b0, 40);

    // Wrap from the last slot back to base
    data_i = 64'hA5A5_0000_0000_0002;
    exp_q.push_back(64'h2018); exp_q.push_back(64'h2000);
    start_req(64'h2000, 16'd3, 4'd8, 16'd3, 16'd2, 16'd2);
    wait_ack(16'd1, 16'd2, 1'b0, 40);

    // Full ring stops early with data still offered
    data_i = 64'hA5A5_0000_0000_0003;
    exp_q.push_back(64'h3000); exp_q.push_back(64'h3008); exp_q.push_back(64'h3010);
    start_req(64'h3000, 16'd3, 4'd8, 16'd0, 16'd0, 16'd5);
    wait_ack(16'd3, 16'd3, 1'b0, 40);

    // Zero count: no stores, head unchanged
    hs_before = hs_cnt;
    start_req(64'h1000, 16'd7, 4'd8, 16'd4, 16'd0, 16'd0);
    wait_ack(16'd4, 16'd0, 1'b0, 10);
    chk("cnt0_latency_ok", 64'(last_lat <= 3), 64'd1);
    chk("cnt0_no_stores", 64'(hs_cnt - hs_before), 64'd0);

    // Outstanding limit with withheld responses
    auto_en = 1'b0;
    data_i = 64'hA5A5_0000_0000_0004;
    exp_q.push_back(64'h4000); exp_q.push_back(64'h4008); exp_q.push_back(64'h4010);
    hs_before = hs_cnt;
    start_req(64'h4000, 16'd7, 4'd8, 16'd0, 16'd0, 16'd3);
    repeat (4) @(negedge clk);
    chk("blocked_valid", 64'(st_valid_o), 64'd0);
    chk("blocked_stores", 64'(hs_cnt - hs_before), 64'd2);
    @(posedge clk); #1; resp_man = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("unblocked_valid", 64'(st_valid_o), 64'd1);
    @(posedge clk); #1; resp_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_no_ack", 64'(cfg_ack_o), 64'd0);
    end
    chk("bp_stores", 64'(hs_cnt - hs_before), 64'd3);
    @(posedge clk); #1; resp_man = 1'b1;
    @(negedge clk);
    chk("ack_not_with_resp", 64'(cfg_ack_o), 64'd0);
    @(posedge clk); #1; resp_man = 1'b0;
    wait_ack(16'd3, 16'd3, 1'b0, 1);
    auto_en = 1'b1;

    // Non-power-of-two size
    data_i = 64'hA5A5_0000_0000_0005;
    hs_before = hs_cnt;
`ifdef STORE_ADDR_GEN_SIZE_CHECK_EN
    start_req(64'h5000, 16'd7, 4'd3, 16'd1, 16'd0, 16'd2);
    wait_ack(16'd1, 16'd0, 1'b1, 10);
    chk("size3_no_stores", 64'(hs_cnt - hs_before), 64'd0);
`else
    exp_q.push_back(64'h5003); exp_q.push_back(64'h5006);
    start_req(64'h5000, 16'd7, 4'd3, 16'd1, 16'd0, 16'd2);
    wait_ack(16'd3, 16'd2, 1'b0, 40);
    chk("size3_stores", 64'(hs_cnt - hs_before), 64'd2);
`endif

    // Reset in the middle of a request
    data_i = 64'hA5A5_0000_0000_0006;
    exp_q.push_back(64'h6000); exp_q.push_back(64'h6008);
    exp_q.push_back(64'h6010); exp_q.push_back(64'h6018);
    start_req(64'h6000, 16'd7, 4'd8, 16'd0, 16'd0, 16'd4);
    @(negedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_st_valid", 64'(st_valid_o), 64'd0);
    chk("mid_rst_data_ready", 64'(data_ready_o), 64'd0);
    chk("mid_rst_ack", 64'(cfg_ack_o), 64'd0);
    chk("mid_rst_head", 64'(cfg_head_ptr_o), 64'd0);
    chk("mid_rst_pushed", 64'(cfg_pushed_o), 64'd0);
    chk("mid_rst_err", 64'(cfg_err_o), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_ack", 64'(cfg_ack_o), 64'd0);
      chk("post_rst_idle", 64'(st_valid_o), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
